// File: rtl/noc_arb_pkg.sv
// Shared definitions for the mesh router output arbitration: packet length
// default, port indices, arbiter state encoding and the one-hot direction
// code used by the router's header/body record logic.
package noc_arb_pkg;

  localparam int PKT_LEN_DEF = 5;
  localparam int SEL_W       = 3;

  localparam logic [SEL_W-1:0] PORT_N = 3'd0;
  localparam logic [SEL_W-1:0] PORT_E = 3'd1;
  localparam logic [SEL_W-1:0] PORT_S = 3'd2;
  localparam logic [SEL_W-1:0] PORT_W = 3'd3;
  localparam logic [SEL_W-1:0] PORT_L = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_e;

  typedef logic [5:0] dir_oh_t;

  localparam dir_oh_t DIR_N    = 6'b000001;
  localparam dir_oh_t DIR_E    = 6'b000010;
  localparam dir_oh_t DIR_S    = 6'b000100;
  localparam dir_oh_t DIR_W    = 6'b001000;
  localparam dir_oh_t DIR_L    = 6'b010000;
  localparam dir_oh_t DIR_IDLE = 6'b100000;

  // Map a binary port index to its one-hot direction code.
  function automatic dir_oh_t port_to_dir(input logic [SEL_W-1:0] port);
    if (port > PORT_L) return DIR_IDLE;
    return dir_oh_t'(6'b000001 << port);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward (with wrap) from the priority pointer.
module rr_pick
  import noc_arb_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_req
);

  assign any_req = |req;

  // Scan requesters starting at ptr and keep the first hit.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] p;
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = '0;
    for (int k = 0; k < N; k++) begin
      p = SEL_W'((int'(ptr) + k) % N);
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = p;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port packet arbiter for the mesh router. Grants one input port
// the output link for a whole packet (header + PKT_LEN-1 body flits) using
// round-robin priority, and drives the crossbar select.
// Optional watchdog enabled with `define ARB_TIMEOUT_EN: aborts a packet
// after TIMEOUT_CYC consecutive stalled cycles.
module output_port_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_IN        = 5,
  parameter int PKT_LEN     = PKT_LEN_DEF,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req_i,
  input  logic [N_IN-1:0]  flit_valid_i,
  input  logic             out_ready_i,
  output logic [N_IN-1:0]  grant_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             xfer_o,
  output logic [CNT_W-1:0] flit_cnt_o,
  output logic             timeout_o
);

  if ((2 ** CNT_W) < PKT_LEN || N_IN > (2 ** SEL_W) || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("output_port_arbiter: inconsistent N_IN/PKT_LEN/CNT_W/TIMEOUT_CYC");
  end

  arb_state_e       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic [N_IN-1:0]  pick_grant;
  logic             any_req;
  logic             is_tail;

  // The owner just served becomes lowest priority.
  assign next_ptr = (sel_o == SEL_W'(N_IN - 1)) ? '0 : sel_o + SEL_W'(1);
  // While a packet is in flight the pick only matters at the tail, where it
  // must start from the post-packet pointer.
  assign pick_ptr = (state == ACTIVE) ? next_ptr : ptr;
  assign is_tail  = (flit_cnt_o == CNT_W'(PKT_LEN - 1));
  assign busy_o   = (state == ACTIVE);
  assign xfer_o   = (state == ACTIVE) && flit_valid_i[sel_o] && out_ready_i;

  rr_pick #(.N(N_IN)) u_pick (
    .req     (req_i),
    .ptr     (pick_ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog;
  logic            wd_expire;
  assign wd_expire = (state == ACTIVE) && !xfer_o && (wdog == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_o = 1'b0;
`endif

  // Arbitration FSM: grant on request, count flits, release or re-grant at the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_o    <= '0;
      sel_o      <= '0;
      flit_cnt_o <= '0;
      ptr        <= '0;
`ifdef ARB_TIMEOUT_EN
      wdog       <= '0;
      timeout_o  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACTIVE;
            grant_o    <= pick_grant;
            sel_o      <= pick_idx;
            flit_cnt_o <= '0;
`ifdef ARB_TIMEOUT_EN
            wdog       <= '0;
`endif
          end
        end
        ACTIVE: begin
          if (xfer_o) begin
`ifdef ARB_TIMEOUT_EN
            wdog <= '0;
`endif
            if (is_tail) begin
              ptr        <= next_ptr;
              flit_cnt_o <= '0;
              if (any_req) begin
                grant_o <= pick_grant;
                sel_o   <= pick_idx;
              end else begin
                state   <= IDLE;
                grant_o <= '0;
              end
            end else begin
              flit_cnt_o <= flit_cnt_o + CNT_W'(1);
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_expire) begin
            state      <= IDLE;
            grant_o    <= '0;
            ptr        <= next_ptr;
            flit_cnt_o <= '0;
            wdog       <= '0;
            timeout_o  <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus
// randomized traffic, all compared against a packet-level reference model.
module tb_output_port_arbiter;

  localparam int N_IN        = 5;
  localparam int PKT_LEN     = 5;
  localparam int CNT_W       = 3;
  localparam int TIMEOUT_CYC = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_IN-1:0]  req_i = '0;
  logic [N_IN-1:0]  flit_valid_i = '0;
  logic             out_ready_i = 1'b0;
  logic [N_IN-1:0]  grant_o;
  logic [2:0]       sel_o;
  logic             busy_o;
  logic             xfer_o;
  logic [CNT_W-1:0] flit_cnt_o;
  logic             timeout_o;

  output_port_arbiter #(
    .N_IN(N_IN), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .flit_valid_i (flit_valid_i),
    .out_ready_i  (out_ready_i),
    .grant_o      (grant_o),
    .sel_o        (sel_o),
    .busy_o       (busy_o),
    .xfer_o       (xfer_o),
    .flit_cnt_o   (flit_cnt_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the link, which flit is next, rotation pointer.
  int m_owner;
  int m_sel;
  int m_cnt;
  int m_ptr;
  int m_wd;
  bit m_to;

  // Observed values from the most recent sample.
  logic [N_IN-1:0]  obs_grant;
  logic [CNT_W-1:0] obs_cnt;
  logic             obs_busy;
  logic             obs_to;
  int               xfer_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [N_IN-1:0] req, input int ptr);
    for (int k = 0; k < N_IN; k++) begin
      logic [2:0] b;
      b = 3'((ptr + k) % N_IN);
      if (req[b]) return int'(b);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_sel   = 0;
    m_cnt   = 0;
    m_ptr   = 0;
    m_wd    = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N_IN-1:0] req, input logic [N_IN-1:0] valid,
                            input logic rdy);
    bit         xf;
    bit         to_n;
    logic [2:0] s;
    s    = 3'(m_sel);
    xf   = (m_owner >= 0) && valid[s] && rdy;
    to_n = 1'b0;
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner = rr(req, m_ptr);
        m_sel   = m_owner;
        m_cnt   = 0;
        m_wd    = 0;
      end
    end else if (xf) begin
      m_wd = 0;
      if (m_cnt == PKT_LEN - 1) begin
        m_ptr = (m_sel + 1) % N_IN;
        m_cnt = 0;
        if (req != '0) begin
          m_owner = rr(req, m_ptr);
          m_sel   = m_owner;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_cnt++;
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      m_wd++;
      if (m_wd == TIMEOUT_CYC) begin
        m_owner = -1;
        m_ptr   = (m_sel + 1) % N_IN;
        m_cnt   = 0;
        m_wd    = 0;
        to_n    = 1'b1;
      end
`endif
    end
    m_to = to_n;
  endtask

  // One clock: drive inputs, compare every output with the model, advance the model.
  task automatic apply(input logic [N_IN-1:0] req, input logic [N_IN-1:0] valid,
                       input logic rdy);
    logic [2:0]  s;
    logic [31:0] exp_grant;
    bit          exp_xfer;
    @(negedge clk);
    req_i        = req;
    flit_valid_i = valid;
    out_ready_i  = rdy;
    #1;
    s         = 3'(m_sel);
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    exp_xfer  = (m_owner >= 0) && valid[s] && rdy;
    check("grant",    32'(grant_o),    exp_grant);
    check("sel",      32'(sel_o),      32'(m_sel));
    check("busy",     32'(busy_o),     32'(m_owner >= 0));
    check("xfer",     32'(xfer_o),     32'(exp_xfer));
    check("flit_cnt", 32'(flit_cnt_o), 32'(m_cnt));
    check("timeout",  32'(timeout_o),  32'(m_to));
    obs_grant = grant_o;
    obs_cnt   = flit_cnt_o;
    obs_busy  = busy_o;
    obs_to    = timeout_o;
    if (xfer_o) xfer_seen++;
    model_step(req, valid, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    req_i        = '0;
    flit_valid_i = '0;
    out_ready_i  = 1'b0;
    @(posedge clk);
    #1;
    check("rst_grant", 32'(grant_o),    32'd0);
    check("rst_busy",  32'(busy_o),     32'd0);
    check("rst_cnt",   32'(flit_cnt_o), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [N_IN-1:0] rand_bits(input int pct);
    logic [N_IN-1:0] v;
    v = '0;
    for (int i = 0; i < N_IN; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  initial begin
    logic [N_IN-1:0] r;
    logic [N_IN-1:0] v;
    model_reset();
    do_reset();
    check("rst_sel", 32'(sel_o), 32'd0);

    // Single requester, no stall.
    xfer_seen = 0;
    apply(5'b00001, 5'h1f, 1'b1);
    repeat (6) apply(5'b00000, 5'h1f, 1'b1);
    check("single_xfers", 32'(xfer_seen), 32'd5);
    check("single_idle", 32'(obs_busy), 32'd0);

    // Round-robin order over three back-to-back packets.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(5'b10101, 5'h1f, 1'b1);
      if (i == 1)  check("rr_first",  32'(obs_grant), 32'b00001);
      if (i == 6)  check("rr_second", 32'(obs_grant), 32'b00100);
      if (i == 11) check("rr_third",  32'(obs_grant), 32'b10000);
    end

    // Stall at flit 2.
    do_reset();
    apply(5'b00001, 5'h1f, 1'b1);
    repeat (2) apply(5'b00000, 5'h1f, 1'b1);
    repeat (3) apply(5'b00000, 5'h1f, 1'b0);
    check("stall_cnt",   32'(obs_cnt),   32'd2);
    check("stall_grant", 32'(obs_grant), 32'b00001);
    repeat (3) apply(5'b00000, 5'h1f, 1'b1);
    apply(5'b00000, 5'h1f, 1'b1);
    check("stall_done", 32'(obs_busy), 32'd0);

    // Non-owner noise: port 1 owns, port 3 toggles.
    do_reset();
    apply(5'b00010, 5'b00010, 1'b1);
    xfer_seen = 0;
    for (int i = 0; i < 7; i++) begin
      v    = '0;
      r    = '0;
      v[1] = (i != 1 && i != 2);
      v[3] = 1'($urandom_range(1));
      r[3] = (i % 2 == 0);
      apply(r, v, 1'b1);
    end
    check("noise_xfers", 32'(xfer_seen), 32'd5);
    apply(5'b00000, 5'h1f, 1'b0);
    check("noise_next", 32'(obs_grant), 32'b01000);

    // Reset mid-packet (pointer had advanced to 1 beforehand).
    do_reset();
    apply(5'b00001, 5'h1f, 1'b1);
    repeat (5) apply(5'b00000, 5'h1f, 1'b1);
    apply(5'b00100, 5'h1f, 1'b1);
    repeat (3) apply(5'b00000, 5'h1f, 1'b1);
    @(negedge clk);
    req_i = '0; flit_valid_i = 5'h1f; out_ready_i = 1'b1;
    #1;
    check("pre_rst_cnt", 32'(flit_cnt_o), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("async_grant", 32'(grant_o),    32'd0);
    check("async_sel",   32'(sel_o),      32'd0);
    check("async_busy",  32'(busy_o),     32'd0);
    check("async_cnt",   32'(flit_cnt_o), 32'd0);
    check("async_xfer",  32'(xfer_o),     32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    apply(5'b00101, 5'h1f, 1'b1);
    apply(5'b00000, 5'h1f, 1'b1);
    check("post_rst_ptr", 32'(obs_grant), 32'b00001);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: owner never presents a flit.
    do_reset();
    apply(5'b00011, 5'b00000, 1'b1);
    repeat (TIMEOUT_CYC) apply(5'b00011, 5'b00000, 1'b1);
    apply(5'b00011, 5'b00000, 1'b1);
    check("wd_pulse", 32'(obs_to),    32'd1);
    check("wd_drop",  32'(obs_grant), 32'd0);
    apply(5'b00000, 5'b00000, 1'b1);
    check("wd_next",  32'(obs_grant), 32'b00010);
`endif

    // Randomized traffic in several regimes.
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        case (p)
          0:       apply(rand_bits(20), rand_bits(75), ($urandom_range(99) < 75));
          1:       apply(rand_bits(70), 5'h1f,         ($urandom_range(99) < 50));
          2:       apply(rand_bits(50), rand_bits(30), ($urandom_range(99) < 90));
          default: apply(rand_bits(40), rand_bits(50), 1'b1);
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port round-robin arbiter for the mesh router.
- Shares one output link among N_IN input ports.
- Locks the grant for a whole packet: header flit plus PKT_LEN-1 body flits.
- Releases the grant after the tail flit and drives the crossbar select for that output.

Parameters:
- N_IN, 5, number of requesting input ports (N, E, S, W, local).
- PKT_LEN, 5, flits per packet, header included.
- CNT_W, 3, flit counter width; must satisfy 2^CNT_W >= PKT_LEN.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  N_IN  input port i has a header flit routed to this output.
- flit_valid_i  input  N_IN  input port i presents a valid flit this cycle.
- out_ready_i  input  1  downstream link accepts a flit this cycle.
- grant_o  output  N_IN  one-hot owner of the output; all zero when idle.
- sel_o  output  3  binary index of the owner, used as the crossbar mux select.
- busy_o  output  1  packet in progress.
- xfer_o  output  1  flit transferred this cycle.
- flit_cnt_o  output  CNT_W  index of the next flit to transfer (0 = header).
- timeout_o  output  1  watchdog abort pulse; tied to 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: asynchronous and active-high. While rst is high, the block is forced immediately to:
  - state IDLE;
  - grant_o = 0, sel_o = 0, busy_o = 0, flit_cnt_o = 0, timeout_o = 0;
  - priority pointer = 0.
- Reset mid-packet: the packet is abandoned; no completion and no pointer update.
- States: IDLE and ACTIVE.
- IDLE:
  - If any req_i bit is high, a round-robin pick is made starting at the pointer.
  - The registered grant appears next cycle: 1-cycle grant latency.
  - State goes to ACTIVE with flit_cnt = 0.
  - If no req_i bit is high, the block stays in IDLE.
- ACTIVE:
  - xfer_o = flit_valid_i[sel] & out_ready_i (combinational).
  - On xfer, flit_cnt increments.
  - No xfer means a stall: all state is held and the grant is kept.
  - req_i and flit_valid_i from non-owners are ignored while ACTIVE.
- Tail: xfer while flit_cnt == PKT_LEN-1.
  - Pointer becomes (sel+1) mod N_IN, and flit_cnt becomes 0.
  - If any req_i is high in the tail cycle, the block re-arbitrates from the new pointer. The new grant is effective next cycle (back-to-back, no bubble) and the state stays ACTIVE.
  - Otherwise state goes to IDLE.
- Fairness: the previous owner has lowest priority when re-arbitrating. Any requester waits at most N_IN-1 packets.
- flit_cnt never exceeds PKT_LEN-1; wrap is only via the tail.
- sel_o and grant_o are always consistent. sel_o holds its last value while IDLE, with grant_o = 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counts consecutive ACTIVE cycles without xfer.
  - On reaching TIMEOUT_CYC, the grant is dropped and the state goes to IDLE.
  - Pointer becomes sel+1 and flit_cnt becomes 0.
  - timeout_o pulses for 1 cycle.
  - The watchdog clears on every xfer and on every new grant.
- Without the macro: no watchdog logic, timeout_o tied to 0, and stalls are unbounded.

Decomposition:
- Package noc_arb_pkg holds:
  - the PKT_LEN default;
  - the port index constants (N=0, E=1, S=2, W=3, L=4);
  - the arbiter state enum (IDLE, ACTIVE);
  - the 6-bit one-hot direction encoding, with the idle code 6'b100000, shared with the router's header/body record logic.
- Sub-module rr_pick: a combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, binary index, any_req.
  - Instantiated once by the arbiter.

Test Plan:
- Single requester, no stall: req_i=00001, flit_valid and out_ready held high.
  - Expect grant_o=00001 one cycle later.
  - Expect 5 xfer pulses, flit_cnt_o 0→4→0, then busy_o=0.
- Round-robin order: req_i=10101 held for 3 packets, pointer 0.
  - Expect grants in order 00001, 00100, 10000, back-to-back with no idle cycle between packets.
- Stall: out_ready_i low for 3 cycles at flit 2.
  - Expect flit_cnt_o held at 2, grant held, no xfer.
  - Expect completion after out_ready_i returns high.
- Non-owner noise: port 1 owns; port 3 toggles flit_valid_i and req_i.
  - Expect xfer_o to follow only port 1's valid.
  - Expect port 3 granted only after port 1's tail.
- Reset mid-packet: assert rst at flit 3.
  - Expect all outputs 0 immediately, without waiting for an edge.
  - Expect the next grant to start from pointer 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=8: owner's flit_valid low for 8 cycles.
  - Expect a timeout_o pulse, grant_o=0, and the next requester granted afterwards.
